// File: rtl/dmem_port_arbiter_pkg.sv
// dmem_port_arbiter_pkg: shared widths, core limits and the round-robin index helper
package dmem_port_arbiter_pkg;
    localparam int ADDR_W_DEF = 32;
    localparam int DATA_W_DEF = 32;
    localparam int MAX_CORES = 8;
    localparam int MAX_IDX_W = $clog2(MAX_CORES);

    // First set bit of elig at or after ptr, wrapping modulo n; 0 when none is set.
    function automatic logic [MAX_IDX_W-1:0] rr_first(
        input logic [MAX_CORES-1:0] elig,
        input logic [MAX_IDX_W-1:0] ptr,
        input int n
    );
        logic [MAX_IDX_W-1:0] idx;
        logic [MAX_IDX_W-1:0] k;
        idx = '0;
        for (int i = MAX_CORES - 1; i >= 0; i--) begin
            k = MAX_IDX_W'((int'(ptr) + i) % n);
            if (i < n && elig[k]) idx = k;
        end
        return idx;
    endfunction
endpackage

// File: rtl/dmem_port_arbiter_rr_picker.sv
// rr_picker: combinational round-robin priority picker returning one-hot grant and its index
module rr_picker
    import dmem_port_arbiter_pkg::*;
#(
    parameter int NUM_CORES = 4,
    parameter int IDX_W = 2
) (
    input  logic [NUM_CORES-1:0] elig,
    input  logic [IDX_W-1:0]     rr_ptr,
    output logic [NUM_CORES-1:0] grant,
    output logic [IDX_W-1:0]     grant_idx
);
    logic [MAX_IDX_W-1:0] idx_full;

    always_comb begin
        idx_full = rr_first(MAX_CORES'(elig), MAX_IDX_W'(rr_ptr), NUM_CORES);
        grant_idx = IDX_W'(idx_full);
        grant = (|elig) ? NUM_CORES'(1) << grant_idx : '0;
    end
endmodule

// File: rtl/dmem_port_arbiter.sv
// dmem_port_arbiter: round-robin sharing of one data-memory port among pipeline cores
module dmem_port_arbiter
    import dmem_port_arbiter_pkg::*;
#(
    parameter int NUM_CORES = 4,
    parameter int IDX_W = 2,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic                        Clk,
    input  logic                        Reset,
    input  logic [NUM_CORES-1:0]        core_req,
    input  logic [NUM_CORES-1:0]        core_we,
    input  logic [NUM_CORES-1:0]        core_half,
    input  logic [NUM_CORES-1:0]        core_byte,
    input  logic [NUM_CORES*ADDR_W-1:0] core_addr,
    input  logic [NUM_CORES*DATA_W-1:0] core_wdata,
    output logic [NUM_CORES-1:0]        core_ack,
    output logic [DATA_W-1:0]           core_rdata,
    output logic [NUM_CORES-1:0]        core_stall,
    output logic                        mem_en,
    output logic                        mem_we,
    output logic                        mem_half,
    output logic                        mem_byte,
    output logic [ADDR_W-1:0]           mem_addr,
    output logic [DATA_W-1:0]           mem_wdata,
    input  logic [DATA_W-1:0]           mem_rdata
);
    logic                 pend_valid;
    logic                 pend_load;
    logic [IDX_W-1:0]     pend_idx;
    logic [IDX_W-1:0]     rr_ptr;
    logic [IDX_W-1:0]     grant_idx;
    logic [NUM_CORES-1:0] pend_oh;
    logic [NUM_CORES-1:0] elig;
    logic [NUM_CORES-1:0] grant;
    logic                 granted;

    // A core awaiting its response this cycle must not be granted again.
    assign pend_oh = pend_valid ? NUM_CORES'(1) << pend_idx : '0;
    assign elig = core_req & ~pend_oh;

    rr_picker #(
        .NUM_CORES(NUM_CORES),
        .IDX_W(IDX_W)
    ) u_picker (
        .elig(elig),
        .rr_ptr(rr_ptr),
        .grant(grant),
        .grant_idx(grant_idx)
    );

    // Reset also silences the memory port while it is held.
    assign granted = (|grant) & ~Reset;

    always_comb begin
        mem_en = granted;
        mem_we = granted & core_we[grant_idx];
        mem_half = granted & core_half[grant_idx];
        mem_byte = granted & core_byte[grant_idx];
        mem_addr = granted ? core_addr[grant_idx*ADDR_W +: ADDR_W] : '0;
        mem_wdata = granted ? core_wdata[grant_idx*DATA_W +: DATA_W] : '0;
    end

    assign core_ack = pend_oh;
    assign core_rdata = (pend_valid & pend_load) ? mem_rdata : '0;
    assign core_stall = core_req & ~core_ack;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            pend_valid <= 1'b0;
            pend_load <= 1'b0;
            pend_idx <= '0;
            rr_ptr <= '0;
        end else begin
            pend_valid <= granted;
            if (granted) begin
                pend_idx <= grant_idx;
                pend_load <= ~core_we[grant_idx];
                rr_ptr <= (grant_idx == IDX_W'(NUM_CORES - 1)) ? '0 : grant_idx + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_dmem_port_arbiter.sv
// tb_dmem_port_arbiter: table-driven vectors plus an async-reset sequence for dmem_port_arbiter
module tb_dmem_port_arbiter;
    logic         Clk;
    logic         Reset;
    logic [3:0]   core_req, core_we, core_half, core_byte;
    logic [127:0] core_addr, core_wdata;
    logic [3:0]   core_ack, core_stall;
    logic [31:0]  core_rdata;
    logic         mem_en, mem_we, mem_half, mem_byte;
    logic [31:0]  mem_addr, mem_wdata, mem_rdata;

    int n_chk = 0;
    int n_fail = 0;

    typedef struct {
        logic [3:0]  req, we, half, byt;
        logic [31:0] rd;
        int          g;
        logic [3:0]  ack;
        logic [31:0] erd;
    } vec_t;

    vec_t v[24];

    dmem_port_arbiter dut (
        .Clk(Clk), .Reset(Reset),
        .core_req(core_req), .core_we(core_we), .core_half(core_half), .core_byte(core_byte),
        .core_addr(core_addr), .core_wdata(core_wdata),
        .core_ack(core_ack), .core_rdata(core_rdata), .core_stall(core_stall),
        .mem_en(mem_en), .mem_we(mem_we), .mem_half(mem_half), .mem_byte(mem_byte),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    function automatic logic [31:0] addr_of(input int k);
        return (k == 3) ? 32'h13 : 32'(k * 32);
    endfunction

    function automatic logic [31:0] wdata_of(input int k);
        return (k == 3) ? 32'hAB : 32'(17 * (k + 1));
    endfunction

    function automatic vec_t mk(input logic [3:0] req, input logic [3:0] we, input logic [3:0] half,
                                input logic [3:0] byt, input logic [31:0] rd, input int g,
                                input logic [3:0] ack, input logic [31:0] erd);
        vec_t r;
        r.req = req; r.we = we; r.half = half; r.byt = byt; r.rd = rd;
        r.g = g; r.ack = ack; r.erd = erd;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    initial begin
        int g;
        for (int k = 0; k < 4; k++) begin
            core_addr[k*32 +: 32] = addr_of(k);
            core_wdata[k*32 +: 32] = wdata_of(k);
        end
        v[0]  = mk(4'b1111, 4'b0000, 4'b0000, 4'b0000, 32'h0,        0, 4'b0000, 32'h0);
        v[1]  = mk(4'b1111, 4'b0000, 4'b0000, 4'b0000, 32'h100,      1, 4'b0001, 32'h100);
        v[2]  = mk(4'b1111, 4'b0000, 4'b0000, 4'b0000, 32'h101,      2, 4'b0010, 32'h101);
        v[3]  = mk(4'b1111, 4'b0000, 4'b0000, 4'b0000, 32'h102,      3, 4'b0100, 32'h102);
        v[4]  = mk(4'b1111, 4'b0000, 4'b0000, 4'b0000, 32'h103,      0, 4'b1000, 32'h103);
        v[5]  = mk(4'b1111, 4'b0000, 4'b0000, 4'b0000, 32'h104,      1, 4'b0001, 32'h104);
        v[6]  = mk(4'b0010, 4'b0000, 4'b0000, 4'b0000, 32'h105,     -1, 4'b0010, 32'h105);
        v[7]  = mk(4'b0000, 4'b0000, 4'b0000, 4'b0000, 32'h106,     -1, 4'b0000, 32'h0);
        v[8]  = mk(4'b0100, 4'b0000, 4'b0000, 4'b0000, 32'h0,        2, 4'b0000, 32'h0);
        v[9]  = mk(4'b0100, 4'b0000, 4'b0000, 4'b0000, 32'hDEADBEEF, -1, 4'b0100, 32'hDEADBEEF);
        v[10] = mk(4'b0000, 4'b0000, 4'b0000, 4'b0000, 32'h0,       -1, 4'b0000, 32'h0);
        v[11] = mk(4'b0010, 4'b0000, 4'b0000, 4'b0000, 32'h0,        1, 4'b0000, 32'h0);
        v[12] = mk(4'b0010, 4'b0000, 4'b0000, 4'b0000, 32'h55,      -1, 4'b0010, 32'h55);
        v[13] = mk(4'b0010, 4'b0000, 4'b0000, 4'b0000, 32'h0,        1, 4'b0000, 32'h0);
        v[14] = mk(4'b0010, 4'b0000, 4'b0000, 4'b0000, 32'h56,      -1, 4'b0010, 32'h56);
        v[15] = mk(4'b0010, 4'b0000, 4'b0000, 4'b0000, 32'h0,        1, 4'b0000, 32'h0);
        v[16] = mk(4'b0010, 4'b0000, 4'b0000, 4'b0000, 32'h57,      -1, 4'b0010, 32'h57);
        v[17] = mk(4'b0000, 4'b0000, 4'b0000, 4'b0000, 32'h0,       -1, 4'b0000, 32'h0);
        v[18] = mk(4'b1000, 4'b1000, 4'b0000, 4'b1000, 32'h0,        3, 4'b0000, 32'h0);
        v[19] = mk(4'b1000, 4'b1000, 4'b0000, 4'b1000, 32'h77,      -1, 4'b1000, 32'h0);
        v[20] = mk(4'b0000, 4'b0000, 4'b0000, 4'b0000, 32'h0,       -1, 4'b0000, 32'h0);
        v[21] = mk(4'b0001, 4'b0001, 4'b0001, 4'b0000, 32'h0,        0, 4'b0000, 32'h0);
        v[22] = mk(4'b0001, 4'b0001, 4'b0001, 4'b0000, 32'h88,      -1, 4'b0001, 32'h0);
        v[23] = mk(4'b0000, 4'b0000, 4'b0000, 4'b0000, 32'h0,       -1, 4'b0000, 32'h0);

        Reset = 1'b1;
        core_req = 4'b1111; core_we = '0; core_half = '0; core_byte = '0; mem_rdata = 32'hFFFF_FFFF;
        repeat (2) @(posedge Clk);
        #1;
        chk("rst_en", 32'(mem_en), 32'h0);
        chk("rst_addr", mem_addr, 32'h0);
        chk("rst_ack", 32'(core_ack), 32'h0);
        chk("rst_rdata", core_rdata, 32'h0);
        core_req = '0;
        mem_rdata = '0;
        Reset = 1'b0;

        for (int i = 0; i < 24; i++) begin
            @(posedge Clk);
            #1;
            core_req = v[i].req; core_we = v[i].we; core_half = v[i].half; core_byte = v[i].byt;
            mem_rdata = v[i].rd;
            @(negedge Clk);
            g = v[i].g;
            chk($sformatf("v%0d_en", i), 32'(mem_en), 32'(g >= 0));
            chk($sformatf("v%0d_addr", i), mem_addr, (g >= 0) ? addr_of(g) : 32'h0);
            chk($sformatf("v%0d_wdata", i), mem_wdata, (g >= 0) ? wdata_of(g) : 32'h0);
            chk($sformatf("v%0d_we", i), 32'(mem_we), (g >= 0) ? 32'(v[i].we[g]) : 32'h0);
            chk($sformatf("v%0d_half", i), 32'(mem_half), (g >= 0) ? 32'(v[i].half[g]) : 32'h0);
            chk($sformatf("v%0d_byte", i), 32'(mem_byte), (g >= 0) ? 32'(v[i].byt[g]) : 32'h0);
            chk($sformatf("v%0d_ack", i), 32'(core_ack), 32'(v[i].ack));
            chk($sformatf("v%0d_rdata", i), core_rdata, v[i].erd);
            chk($sformatf("v%0d_stall", i), 32'(core_stall), 32'(v[i].req & ~v[i].ack));
        end

        // Reset lands in the response cycle of a core 0 load.
        @(posedge Clk);
        #1;
        core_req = 4'b0001; core_we = '0; core_half = '0; core_byte = '0; mem_rdata = '0;
        @(negedge Clk);
        chk("rs_grant_en", 32'(mem_en), 32'h1);
        chk("rs_grant_addr", mem_addr, 32'h0);
        @(posedge Clk);
        #1;
        mem_rdata = 32'h99;
        @(negedge Clk);
        chk("rs_ack_pre", 32'(core_ack), 32'h1);
        chk("rs_rdata_pre", core_rdata, 32'h99);
        #1 Reset = 1'b1;
        #1;
        chk("rs_ack_async", 32'(core_ack), 32'h0);
        chk("rs_rdata_async", core_rdata, 32'h0);
        chk("rs_en_async", 32'(mem_en), 32'h0);
        chk("rs_stall_async", 32'(core_stall), 32'h1);
        @(posedge Clk);
        #3;
        chk("rs_ack_held", 32'(core_ack), 32'h0);
        @(negedge Clk);
        #1;
        Reset = 1'b0;
        core_req = 4'b0101;
        #1;
        chk("rs_post_en", 32'(mem_en), 32'h1);
        chk("rs_post_addr", mem_addr, 32'h0);
        chk("rs_post_ack", 32'(core_ack), 32'h0);
        @(posedge Clk);
        #1;
        core_req = 4'b0100;
        mem_rdata = 32'h5A;
        @(negedge Clk);
        chk("rs_post_ack2", 32'(core_ack), 32'h1);
        chk("rs_post_rdata", core_rdata, 32'h5A);
        chk("rs_next_addr", mem_addr, 32'h40);
        chk("rs_next_stall", 32'(core_stall), 32'h4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/dmem_port_arbiter.md
Name: dmem_port_arbiter

Overview:
- Shares the single data-memory port among NUM_CORES pipeline cores of the multicore processor.
- Each core's MEM stage raises a request for loads, stores, SAD window/frame fetches and buffer loads.
- The arbiter grants one request per cycle using a round-robin policy and drives the shared memory port.
- It returns read data with a 1-cycle latency and gives each core a stall signal, which feeds that core's ID/MEM stall logic.

Parameters:
- NUM_CORES, 4, number of requesting cores (2..8).
- IDX_W, 2, width of a core index; must equal ceil(log2(NUM_CORES)).
- ADDR_W, 32, byte address width.
- DATA_W, 32, data width.

Ports:
- Clk  in  1  system clock, rising edge.
- Reset  in  1  asynchronous, active-high reset.
- core_req  in  NUM_CORES  per-core request, level; held until that core's ack.
- core_we  in  NUM_CORES  1 = store, 0 = load.
- core_half  in  NUM_CORES  halfword access.
- core_byte  in  NUM_CORES  byte access (half and byte both set is illegal).
- core_addr  in  NUM_CORES*ADDR_W  packed addresses; core k occupies bits [k*ADDR_W +: ADDR_W].
- core_wdata  in  NUM_CORES*DATA_W  packed store data.
- core_ack  out  NUM_CORES  one-hot pulse: the access has completed.
- core_rdata  out  DATA_W  load data, broadcast to all cores; valid with core_ack.
- core_stall  out  NUM_CORES  equals core_req & ~core_ack.
- mem_en  out  1  memory access this cycle.
- mem_we  out  1  memory write enable.
- mem_half  out  1  halfword control to memory.
- mem_byte  out  1  byte control to memory.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  synchronous-read data; valid the cycle after mem_en.

Behaviour:
- Reset (async, any time):
  - rr_ptr = 0, pend_valid = 0, pend_idx = 0.
  - core_ack = 0, core_rdata = 0, all mem_* outputs = 0.
  - An in-flight access is dropped; no ack is issued for it.
  - A store already presented to memory in that cycle may have completed; this is accepted.
- Eligibility:
  - elig[k] = core_req[k] & ~(pend_valid & pend_idx == k).
  - A core whose response is pending this cycle cannot be re-granted. A lone requester is therefore served at most every other cycle.
- Grant (combinational within the cycle):
  - Select the first eligible core scanning rr_ptr, rr_ptr+1, ..., wrapping modulo NUM_CORES.
  - If any core is eligible: mem_en = 1, and mem_we/half/byte/addr/wdata come from the granted core. Otherwise mem_en = 0 and the other mem_* outputs = 0.
- Register update on the Clk edge:
  - If a grant occurred: pend_valid <= 1, pend_idx <= granted core, rr_ptr <= (granted + 1) mod NUM_CORES.
  - If no grant occurred: pend_valid <= 0 and rr_ptr is held.
- Response cycle (the cycle after a grant):
  - core_ack[pend_idx] = pend_valid.
  - core_rdata = mem_rdata when pend_valid and the access was a load; otherwise 0.
  - Stores are acked the same way; core_rdata = 0 for them.
- Latency and throughput:
  - Exactly 1 cycle from grant to ack, for loads and stores alike.
  - Up to one grant per cycle, pipelined, overlapping with the response of the previous grant.
- Fairness: with all cores requesting continuously, grants rotate 0, 1, 2, 3, 0, ... A requester waits at most NUM_CORES-1 grants.
- Simultaneous events:
  - A grant to core j and an ack to core i != j may occur in the same cycle.
  - A core deasserting req without an ack is a protocol violation; the access it had been granted still completes and is acked.
- Sub-word load extension stays in the memory block; the arbiter passes mem_rdata through unchanged.

Decomposition:
- Shared package:
  - ADDR_W and DATA_W defaults.
  - A MAX_CORES constant.
  - A function computing the round-robin index (first eligible at or after ptr, with wrap).
- One natural sub-module, rr_picker: combinational NUM_CORES-wide round-robin priority picker. Inputs are elig and rr_ptr; outputs are a one-hot grant and IDX_W grant_idx. It is reused by the future shared min/tag register arbiter.

Test Plan:
- Single load: core 2 requests a load at addr 0x40; mem_rdata = 0xDEADBEEF the next cycle.
  - Required: mem_en = 1 with addr 0x40 in cycle 0.
  - Required: core_ack = 4'b0100 and core_rdata = 0xDEADBEEF in cycle 1.
  - Required: core_stall[2] = 1 in cycle 0 and 0 in cycle 1.
- Round robin: all four cores request continuously.
  - Required: grants 0, 1, 2, 3, 0, 1 in consecutive cycles.
  - Required: each ack follows its grant by one cycle.
  - Required: no gap cycles.
- Lone requester: only core 1 holds req for 3 accesses.
  - Required: grants in cycles 0, 2, 4.
  - Required: acks in cycles 1, 3, 5.
  - Required: mem_en = 0 in cycles 1 and 3.
- Store sizes: core 3 issues sb with addr 0x13 and wdata 0xAB.
  - Required: mem_we = 1, mem_byte = 1, mem_half = 0, mem_addr = 0x13.
  - Required: ack next cycle with core_rdata = 0.
- Reset mid-operation: Reset is asserted in the response cycle of a core 0 load.
  - Required: core_ack = 0 immediately (asynchronously).
  - Required: after release, rr_ptr = 0 and the next grant goes to the lowest-index requester.
